key_map_loader: RTL and testbench
=================================

KEY_MAP_LOADER -- requirements
Module: key_map_loader

Interface
REQ-001 Parameters SHALL be NUM_KEYS, 8, number of note-key table entries (2..32).
REQ-002 Parameters SHALL include CODE_W, 8, scancode width in bits.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a remap session.
REQ-006 Port abort  input  1  one-cycle request to cancel a session.
REQ-007 Port write_en  input  1  key strobe; key sampled when high.
REQ-008 Port key  input  CODE_W  scancode byte from the keyboard receiver.
REQ-009 Port query_valid  input  1  lookup request strobe.
REQ-010 Port query_key  input  CODE_W  scancode to look up.
REQ-011 Port pattern_flat  output  NUM_KEYS*CODE_W  table; entry i occupies bits [i*CODE_W +: CODE_W].
REQ-012 Port busy  output  1  high while a session is active.
REQ-013 Port done  output  1  one-cycle pulse when the last entry is written.
REQ-014 Port wr_idx  output  $clog2(NUM_KEYS)  next entry to be written.
REQ-015 Port hit  output  1  registered lookup match flag.
REQ-016 Port hit_idx  output  $clog2(NUM_KEYS)  registered matching entry index.
REQ-017 Port dup_err  output  1  one-cycle pulse on a rejected duplicate.

Function
REQ-018 FSM SHALL have three states: IDLE, CAPTURE, SKIP; busy = (state != IDLE).
REQ-019 In IDLE, start SHALL move to CAPTURE with wr_idx=0; write_en in the same cycle is ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 In CAPTURE, when write_en and key==8'hE0, the code SHALL be discarded and the state held.
REQ-022 In CAPTURE, when write_en and key==8'hF0, the FSM SHALL move to SKIP with no write.
REQ-023 In SKIP, when write_en and key==8'hE0, the state SHALL be held; any other code SHALL be discarded and the FSM returns to CAPTURE.
REQ-024 In CAPTURE, any other strobed code SHALL be written to entry wr_idx at the next edge, and wr_idx SHALL increment.
REQ-025 A write to entry NUM_KEYS-1 SHALL pulse done for exactly one cycle, return to IDLE and reset wr_idx to 0.
REQ-026 abort in CAPTURE or SKIP SHALL return to IDLE with no done pulse, keep entries already written, and set wr_idx=0.
REQ-027 abort and start asserted together in IDLE SHALL be treated as start.
REQ-028 Lookup SHALL have latency 1: hit/hit_idx register the lowest-index entry equal to query_key; outputs hold when query_valid is low.
REQ-029 While busy, a query SHALL return hit=0, hit_idx=0.
REQ-030 Codes of width other than 8 SHALL compare against E0/F0 zero-extended to CODE_W.

Reset
REQ-031 rst SHALL immediately set the state to IDLE, busy=0, done=0, dup_err=0, hit=0, hit_idx=0, wr_idx=0.
REQ-032 rst SHALL load entries 0..7 with 1C,1B,23,2B,34,33,3B,42 (do..do2), and entries 8 and above with 0.
REQ-033 rst during a session SHALL discard the session, and the default table SHALL be restored.

Configuration
REQ-034 Macro KEYMAP_DUP_REJECT_EN defined: in CAPTURE, a code equal to an entry with index < wr_idx SHALL be discarded, pulse dup_err for one cycle, and leave wr_idx unchanged.
REQ-035 Macro undefined: duplicates SHALL be written normally, and dup_err SHALL be tied 0.

Verification
REQ-036 After reset, query 23 -> hit=1, hit_idx=2 on the next cycle; query 99 -> hit=0.
REQ-037 start, then codes 15,F0,15,1D,E0,F0,24,24,2D,2C,35,3C,43 -> entries 15,1D,24,2D,2C,35,3C,43; done pulses once after 43; busy=0.
REQ-038 start, then 15,1D, then abort -> entries 0,1 = 15,1D; entries 2..7 keep their defaults; no done pulse; wr_idx=0.
REQ-039 start, then 15,15 with KEYMAP_DUP_REJECT_EN -> second code rejected, dup_err pulses, wr_idx=1; without the macro -> wr_idx=2.
REQ-040 rst asserted mid-session after 3 codes -> busy=0 immediately; table returns to defaults 1C..42.
REQ-041 NUM_KEYS=12: a 12-code session -> done pulses after the 12th code; entries 8..11 read 0 after reset.

Source files
------------

// File: rtl/key_map_loader.sv
// Note-key table loader: captures keyboard scancodes into a NUM_KEYS-entry table and answers
// registered lookups. Define KEYMAP_DUP_REJECT_EN to reject codes already captured this session.
module key_map_loader #(
  parameter int NUM_KEYS = 8,
  parameter int CODE_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         write_en,
  input  logic [CODE_W-1:0]            key,
  input  logic                         query_valid,
  input  logic [CODE_W-1:0]            query_key,
  output logic [NUM_KEYS*CODE_W-1:0]   pattern_flat,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_KEYS)-1:0]  wr_idx,
  output logic                         hit,
  output logic [$clog2(NUM_KEYS)-1:0]  hit_idx,
  output logic                         dup_err
);

  // state   | meaning
  // IDLE    | no session; table stable, lookups answered
  // CAPTURE | each plain scancode fills entry wr_idx
  // SKIP    | break prefix seen; next non-E0 code is the released key and is dropped
  typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_KEYS - 1);
  localparam logic [CODE_W-1:0] CODE_E0  = CODE_W'(8'hE0);
  localparam logic [CODE_W-1:0] CODE_F0  = CODE_W'(8'hF0);

  state_t            state, nxt_state;
  logic [IDX_W-1:0]  nxt_wr_idx;
  logic              wr_fire;
  logic              done_set;
  logic              dup_hit;
  logic [CODE_W-1:0] entries [NUM_KEYS];
  logic              found;
  logic [IDX_W-1:0]  found_idx;

  // Power-on table: one octave do..do2
  function automatic logic [CODE_W-1:0] def_entry(input int i);
    case (i)
      0:       return CODE_W'(8'h1C);
      1:       return CODE_W'(8'h1B);
      2:       return CODE_W'(8'h23);
      3:       return CODE_W'(8'h2B);
      4:       return CODE_W'(8'h34);
      5:       return CODE_W'(8'h33);
      6:       return CODE_W'(8'h3B);
      7:       return CODE_W'(8'h42);
      default: return '0;
    endcase
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    pattern_flat = '0;
    for (int i = 0; i < NUM_KEYS; i++) pattern_flat[i*CODE_W +: CODE_W] = entries[i];
  end

`ifdef KEYMAP_DUP_REJECT_EN
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      if ((IDX_W'(i) < wr_idx) && (entries[i] == key)) dup_hit = 1'b1;
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_idx <= '0;
      done   <= 1'b0;
    end else begin
      state  <= nxt_state;
      wr_idx <= nxt_wr_idx;
      done   <= done_set;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_wr_idx = wr_idx;
    wr_fire    = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        // start wins over a simultaneous abort; a same-cycle key strobe is dropped
        if (start) begin
          nxt_state  = CAPTURE;
          nxt_wr_idx = '0;
        end
      end
      CAPTURE: begin
        if (abort) begin
          nxt_state  = IDLE;
          nxt_wr_idx = '0;
        end else if (write_en) begin
          if (key == CODE_E0) begin
            nxt_state = CAPTURE;
          end else if (key == CODE_F0) begin
            nxt_state = SKIP;
          end else if (!dup_hit) begin
            wr_fire = 1'b1;
            if (wr_idx == LAST_IDX) begin
              done_set   = 1'b1;
              nxt_state  = IDLE;
              nxt_wr_idx = '0;
            end else begin
              nxt_wr_idx = wr_idx + 1'b1;
            end
          end
        end
      end
      SKIP: begin
        if (abort) begin
          nxt_state  = IDLE;
          nxt_wr_idx = '0;
        end else if (write_en && (key != CODE_E0)) begin
          nxt_state = CAPTURE;
        end
      end
      default: begin
        nxt_state  = IDLE;
        nxt_wr_idx = '0;
      end
    endcase
  end

`ifdef KEYMAP_DUP_REJECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dup_err <= 1'b0;
    else     dup_err <= (state == CAPTURE) && !abort && write_en &&
                        (key != CODE_E0) && (key != CODE_F0) && dup_hit;
  end
`else
  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) entries[i] <= def_entry(i);
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_KEYS; i++)
        if (IDX_W'(i) == wr_idx) entries[i] <= key;
    end
  end

  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (entries[i] == query_key) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit     <= 1'b0;
      hit_idx <= '0;
    end else if (query_valid) begin
      hit     <= busy ? 1'b0 : found;
      hit_idx <= busy ? '0 : found_idx;
    end
  end

endmodule

// File: tb/tb_key_map_loader.sv
// Directed bench for key_map_loader: default 8-entry instance plus a 12-entry instance.
module tb_key_map_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, write_en, query_valid;
  logic [7:0]  key, query_key;
  logic [63:0] pattern_flat;
  logic        busy, done, hit, dup_err;
  logic [2:0]  wr_idx, hit_idx;

  logic        start12, write_en12;
  logic [7:0]  key12;
  logic [95:0] pattern12;
  logic        busy12, done12, hit12, dup12;
  logic [3:0]  wr_idx12, hit_idx12;
  logic [95:0] exp12;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] DEF_TABLE = 64'h423B33342B231B1C;

  always #5 clk = ~clk;

  key_map_loader #(.NUM_KEYS(8), .CODE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .write_en(write_en), .key(key),
    .query_valid(query_valid), .query_key(query_key), .pattern_flat(pattern_flat),
    .busy(busy), .done(done), .wr_idx(wr_idx), .hit(hit), .hit_idx(hit_idx), .dup_err(dup_err)
  );

  key_map_loader #(.NUM_KEYS(12), .CODE_W(8)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .abort(1'b0), .write_en(write_en12), .key(key12),
    .query_valid(1'b0), .query_key(8'h00), .pattern_flat(pattern12),
    .busy(busy12), .done(done12), .wr_idx(wr_idx12), .hit(hit12), .hit_idx(hit_idx12),
    .dup_err(dup12)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] k);
    write_en = 1'b1;
    key      = k;
    tick();
    write_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; write_en = 0; key = 0; query_valid = 0; query_key = 0;
    start12 = 0; write_en12 = 0; key12 = 0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_done", done, 0);
    check("rst_hit", {hit, hit_idx}, 0);
    check("rst_dup", dup_err, 0);
    check("rst_table", pattern_flat, DEF_TABLE);
    check("rst_table12", pattern12, {32'h0, DEF_TABLE});
    tick();
    rst = 1'b0;
    tick();

    // lookups against the default table
    query_valid = 1; query_key = 8'h23; tick();
    check("q23", {hit, hit_idx}, {1'b1, 3'd2});
    query_key = 8'h99; tick();
    check("q99", hit, 0);
    query_key = 8'h42; tick();
    check("q42", {hit, hit_idx}, {1'b1, 3'd7});
    query_valid = 0; query_key = 8'h99; tick();
    check("q_hold", {hit, hit_idx}, {1'b1, 3'd7});

    // full session with prefixes; a key strobe alongside start is dropped
    start = 1; write_en = 1; key = 8'h55; tick();
    start = 0; write_en = 0;
    check("start_busy", busy, 1);
    check("start_wr_idx", wr_idx, 0);
    query_valid = 1; query_key = 8'h1C; tick(); query_valid = 0;
    check("q_busy", {hit, hit_idx}, 0);
    send(8'h15);
    start = 1; tick(); start = 0;
    check("start_ignored", {busy, wr_idx}, {1'b1, 3'd1});
    send(8'hF0); send(8'h15); send(8'h1D); send(8'hE0);
    check("e0_hold", wr_idx, 2);
    send(8'hF0); send(8'h24);
    check("skip_drop", wr_idx, 2);
    send(8'h24); send(8'h2D); send(8'h2C); send(8'h35); send(8'h3C);
    check("no_early_done", {done, wr_idx}, {1'b0, 3'd7});
    send(8'h43);
    check("done_pulse", {done, busy, wr_idx}, {1'b1, 1'b0, 3'd0});
    check("session_table", pattern_flat, 64'h433C352C2D241D15);
    tick();
    check("done_one_cycle", done, 0);
    query_valid = 1; query_key = 8'h3C; tick(); query_valid = 0;
    check("q_new", {hit, hit_idx}, {1'b1, 3'd6});

    // abort keeps partial writes
    do_reset();
    start = 1; tick(); start = 0;
    send(8'h15); send(8'h1D);
    abort = 1; tick(); abort = 0;
    check("abort_state", {busy, done, wr_idx}, 0);
    check("abort_table", pattern_flat, 64'h423B33342B231D15);
    tick();
    check("abort_no_done", done, 0);

    // abort with start in IDLE acts as start
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    check("abort_start", {busy, wr_idx}, {1'b1, 3'd0});
    send(8'hF0);
    abort = 1; tick(); abort = 0;
    check("abort_skip", {busy, wr_idx}, 0);

    // duplicate handling
    do_reset();
    start = 1; tick(); start = 0;
    send(8'h15); send(8'h15);
`ifdef KEYMAP_DUP_REJECT_EN
    check("dup_idx", {dup_err, wr_idx}, {1'b1, 3'd1});
    tick();
    check("dup_one_cycle", dup_err, 0);
`else
    check("dup_idx", {dup_err, wr_idx}, {1'b0, 3'd2});
`endif
    abort = 1; tick(); abort = 0;
    query_valid = 1; query_key = 8'h15; tick(); query_valid = 0;
    check("q_lowest", {hit, hit_idx}, {1'b1, 3'd0});

    // reset mid-session restores defaults immediately
    start = 1; tick(); start = 0;
    send(8'h11); send(8'h12); send(8'h13);
    check("pre_rst", {busy, wr_idx}, {1'b1, 3'd3});
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", {busy, wr_idx, hit}, 0);
    check("rst_mid_table", pattern_flat, DEF_TABLE);
    tick();
    rst = 1'b0;
    tick();

    // 12-entry instance
    check("t12_rst", pattern12, {32'h0, DEF_TABLE});
    exp12 = '0;
    start12 = 1; tick(); start12 = 0;
    for (int i = 0; i < 12; i++) begin
      write_en12 = 1; key12 = 8'h60 + 8'(i); exp12[i*8 +: 8] = 8'h60 + 8'(i);
      tick();
      write_en12 = 0;
      if (i == 10) check("t12_no_done", {done12, busy12, wr_idx12}, {1'b0, 1'b1, 4'd11});
    end
    check("t12_done", {done12, busy12, wr_idx12}, {1'b1, 1'b0, 4'd0});
    check("t12_table", pattern12, exp12);
    tick();
    check("t12_done_one", done12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
